// File: rtl/rgb_led_sched.sv
// rgb_led_sched: fixed-priority tri-colour LED sharing with minimum hold, guard blanking and period-aligned PWM.
// Define LED_FADE_EN to fade each duty one LSB per period toward the owner's colour.
module rgb_led_sched #(
    parameter int N_REQ         = 3,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 188,
    parameter int MIN_HOLD      = 16,
    parameter int GUARD_PERIODS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*3*PWM_BITS-1:0] color,
    output logic [N_REQ-1:0]            gnt,
    output logic                        red_pwm,
    output logic                        green_pwm,
    output logic                        blue_pwm,
    output logic                        led_en,
    output logic                        period_start
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int OW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int HW = MIN_HOLD > 0 ? $clog2(MIN_HOLD + 1) : 1;
    localparam int GW = GUARD_PERIODS > 1 ? $clog2(GUARD_PERIODS) : 1;
    localparam int CW = 3 * PWM_BITS;

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t               state_q;
    logic [PW-1:0]        presc_q;
    logic [PWM_BITS-1:0]  cnt_q;
    logic [OW-1:0]        owner_q;
    logic [OW-1:0]        low_idx;
    logic [HW-1:0]        hold_q;
    logic [GW-1:0]        guard_q;
    logic [N_REQ-1:0]     gnt_q;
    logic [CW-1:0]        duty_q;
    logic [CW-1:0]        duty_d;
    logic [CW-1:0]        tgt;
    logic [CW-1:0]        col [N_REQ];
    logic                 red_q, green_q, blue_q, led_en_q, ps_q;
    logic                 tick, bnd, take, hi_req;

    for (genvar i = 0; i < N_REQ; i++) begin : g_col
        assign col[i] = color[i*CW +: CW];
    end

    assign tick   = presc_q == PW'(PRESCALE - 1);
    assign bnd    = tick && (&cnt_q);
    // IDLE and an expiring GUARD share the same arbitration path
    assign take   = state_q == IDLE || (state_q == GUARD && guard_q == GW'(GUARD_PERIODS - 1));
    assign hi_req = |(req & ~({N_REQ{1'b1}} << owner_q));
    assign tgt    = col[take ? low_idx : owner_q];

    always_comb begin
        low_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (req[i]) low_idx = OW'(i);
    end

`ifdef LED_FADE_EN
    always_comb begin
        duty_d = duty_q;
        for (int c = 0; c < 3; c++) begin
            if (duty_q[c*PWM_BITS +: PWM_BITS] < tgt[c*PWM_BITS +: PWM_BITS])
                duty_d[c*PWM_BITS +: PWM_BITS] = duty_q[c*PWM_BITS +: PWM_BITS] + 1'b1;
            else if (duty_q[c*PWM_BITS +: PWM_BITS] > tgt[c*PWM_BITS +: PWM_BITS])
                duty_d[c*PWM_BITS +: PWM_BITS] = duty_q[c*PWM_BITS +: PWM_BITS] - 1'b1;
        end
    end
`else
    assign duty_d = tgt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            owner_q  <= '0;
            hold_q   <= '0;
            guard_q  <= '0;
            gnt_q    <= '0;
            duty_q   <= '0;
            red_q    <= 1'b0;
            green_q  <= 1'b0;
            blue_q   <= 1'b0;
            led_en_q <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) cnt_q <= cnt_q + 1'b1;
            ps_q    <= bnd;
            red_q   <= cnt_q < duty_q[2*PWM_BITS +: PWM_BITS];
            green_q <= cnt_q < duty_q[PWM_BITS +: PWM_BITS];
            blue_q  <= cnt_q < duty_q[0 +: PWM_BITS];
            if (bnd) begin
                if (take) begin
                    state_q  <= |req ? GRANT : IDLE;
                    led_en_q <= |req;
                    owner_q  <= low_idx;
                    gnt_q    <= |req ? N_REQ'(1) << low_idx : '0;
                    duty_q   <= |req ? duty_d : '0;
                    hold_q   <= '0;
                    guard_q  <= '0;
                end else if (state_q == GUARD) begin
                    guard_q <= guard_q + 1'b1;
                end else if (!req[owner_q] || (hold_q == HW'(MIN_HOLD) && hi_req)) begin
                    state_q <= GUARD;
                    gnt_q   <= '0;
                    duty_q  <= '0;
                    guard_q <= '0;
                end else begin
                    hold_q <= hold_q == HW'(MIN_HOLD) ? hold_q : hold_q + 1'b1;
                    duty_q <= duty_d;
                end
            end
        end
    end

    assign gnt          = gnt_q;
    assign red_pwm      = red_q;
    assign green_pwm    = green_q;
    assign blue_pwm     = blue_q;
    assign led_en       = led_en_q;
    assign period_start = ps_q;
endmodule

// File: tb/tb_rgb_led_sched.sv
// tb_rgb_led_sched: directed checks of arbitration, hold, guard, PWM duty and reset for rgb_led_sched.
module tb_rgb_led_sched;
    localparam int N = 3;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*3*B-1:0] color;
    logic [N-1:0]   gnt;
    logic           red_pwm, green_pwm, blue_pwm, led_en, period_start;
    int             tests = 0;
    int             fails = 0;
    int             n;

    always #5 clk = ~clk;

    rgb_led_sched #(.N_REQ(N), .PWM_BITS(B), .PRESCALE(2), .MIN_HOLD(2), .GUARD_PERIODS(1)) dut (
        .clk(clk), .rst(rst), .req(req), .color(color), .gnt(gnt),
        .red_pwm(red_pwm), .green_pwm(green_pwm), .blue_pwm(blue_pwm),
        .led_en(led_en), .period_start(period_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ps(input string tag, input int expn);
        int k = 0;
        do begin @(negedge clk); k++; end while (!period_start && k < 100);
        chk(tag, k, expn);
    endtask

    task automatic chk_pwm(input string tag, input int er, input int eg, input int eb);
        int r = 0, g = 0, b = 0;
        repeat (32) begin
            @(negedge clk);
            r += int'(red_pwm);
            g += int'(green_pwm);
            b += int'(blue_pwm);
        end
`ifdef LED_FADE_EN
        if (er + eg + eb != 0) return;
`endif
        chk({tag, "_red"}, r, er);
        chk({tag, "_green"}, g, eg);
        chk({tag, "_blue"}, b, eb);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_led_en"}, led_en, 0);
        chk({tag, "_pwm"}, {red_pwm, green_pwm, blue_pwm}, 0);
        chk({tag, "_ps"}, period_start, 0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        color = '0;
        repeat (3) @(negedge clk);
        chk_dark("in_reset");
        rst = 1'b0;
        wait_ps("first_period", 32);
        chk("idle_gnt", gnt, 0);
        chk("idle_led_en", led_en, 0);
        wait_ps("period", 32);

        color[12 +: 12] = 12'h40F;
        req = 3'b010;
        chk("pre_grant_gnt", gnt, 0);
        wait_ps("grant_latency", 32);
        chk("grant1_gnt", gnt, 3'b010);
        chk("grant1_led_en", led_en, 1);
        chk_pwm("own1", 8, 0, 30);
        chk("own1_led_en", led_en, 1);

        req = 3'b011;
        wait_ps("b2", 32);
        chk("no_preempt_gnt", gnt, 3'b010);
        wait_ps("b3", 32);
        chk("preempt_guard_gnt", gnt, 0);
        chk("preempt_guard_led_en", led_en, 1);
        chk_pwm("guard", 0, 0, 0);
        chk("grant0_gnt", gnt, 3'b001);

        req = 3'b101;
        repeat (3) wait_ps("hold0", 32);
        chk("low_no_preempt_gnt", gnt, 3'b001);

        req = 3'b000;
        wait_ps("drop0", 32);
        chk("drop0_gnt", gnt, 0);
        chk("drop0_led_en", led_en, 1);
        wait_ps("to_idle", 32);
        chk("to_idle_gnt", gnt, 0);
        chk("to_idle_led_en", led_en, 0);

        color[24 +: 12] = 12'h091;
        req = 3'b110;
        wait_ps("tie", 32);
        chk("tie_gnt", gnt, 3'b010);
        repeat (10) @(negedge clk);
        req = 3'b100;
        repeat (2) @(negedge clk);
        chk("hold_to_boundary_gnt", gnt, 3'b010);
        wait_ps("drop1", 20);
        chk("drop1_guard_gnt", gnt, 0);
        wait_ps("regrant", 32);
        chk("grant2_gnt", gnt, 3'b100);
        color[24 +: 12] = 12'hFFF;
        chk_pwm("colour_ignored", 0, 18, 2);
        chk_pwm("colour_live", 30, 30, 30);
        chk("live_gnt", gnt, 3'b100);

        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_dark("mid_reset");
        wait_ps("after_reset", 32);
        chk("after_reset_gnt", gnt, 3'b100);

`ifdef LED_FADE_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        color[0 +: 12] = 12'hF00;
        req = 3'b001;
        wait_ps("fade_grant", 32);
        chk("fade_gnt", gnt, 3'b001);
        for (int k = 1; k <= 15; k++) begin
            int r = 0;
            repeat (32) begin
                @(negedge clk);
                r += int'(red_pwm);
            end
            chk("fade_red", r, 2 * k);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rgb_led_sched.md
Name: rgb_led_sched

Overview:
- Time-shares the tri-colour LED between N_REQ requesters, e.g. boot status, USB activity and user pins.
- Each requester presents a 24-bit colour. The block arbitrates by fixed priority with a minimum hold time and a blanking guard between owners.
- Generates per-channel PWM with period-aligned duty updates.
- Outputs feed the RGBA hard driver PWM inputs and its enable pins directly; board colour-to-RGBn mapping stays outside this block.

Parameters:
- N_REQ, 3: number of requesters; index 0 has highest priority.
- PWM_BITS, 8: PWM counter and duty width.
- PRESCALE, 188: clk cycles per PWM tick (48 MHz / 188 / 256 ≈ 1 kHz period); must be ≥ 1.
- MIN_HOLD, 16: completed PWM periods an owner keeps the LED before it can be preempted.
- GUARD_PERIODS, 1: dark periods between owners; must be ≥ 1.

Ports:
- clk  in  1  system clock, 48 MHz, from the global buffer.
- rst  in  1  synchronous reset, active high.
- req  in  N_REQ  per-requester request level.
- color  in  N_REQ*3*PWM_BITS  packed per requester as {red, green, blue}; requester i occupies slice i.
- gnt  out  N_REQ  one-hot grant, or all zero.
- red_pwm  out  1  red PWM to driver.
- green_pwm  out  1  green PWM to driver.
- blue_pwm  out  1  blue PWM to driver.
- led_en  out  1  drives CURREN/RGBLEDEN.
- period_start  out  1  one-cycle pulse at each PWM period start.

Behaviour:
- Reset: every counter, gnt, duty registers, all PWM outputs, led_en and period_start are 0; state IDLE. Asserting rst mid-operation forces these values on the next edge, regardless of state.
- Prescaler runs 0..PRESCALE-1; tick is the cycle where prescaler == PRESCALE-1.
- pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0. A boundary is a tick with pwm_cnt == max.
- Registered at each boundary: period_start (high exactly one cycle, coincident with pwm_cnt == 0), the FSM step, gnt, and the duty latches.
- Channel output = (pwm_cnt < duty_latched), registered:
  - duty 0 gives constant low;
  - duty max gives high for 2^PWM_BITS-1 of 2^PWM_BITS ticks.
- color changes mid-period are ignored until the next boundary. An owner may change colour live; the change takes effect the following period.
- FSM, evaluated only at boundaries:
  - IDLE: if any req, grant the lowest set index, hold=0, go GRANT; else stay, duty=0.
  - GRANT, step 1: if req[owner]==0, gnt=0 and go GUARD; this wins over simultaneous preemption.
  - GRANT, step 2: else, if hold ≥ MIN_HOLD and a lower index j is requesting, gnt=0 and go GUARD.
  - GRANT, step 3: else, hold=min(hold+1, MIN_HOLD) and duty = color[owner].
  - GUARD: duty=0. Count GUARD_PERIODS boundaries, then behave as IDLE at that same boundary; a pending req is granted without an extra period.
- Tie-breaks and ownership rules:
  - Simultaneous reqs resolve to the lowest index.
  - A lower-priority req never preempts.
  - A requester dropping req mid-period keeps gnt and light until the boundary.
- Grant latency: gnt rises in the cycle after the first boundary following req assertion. Its colour appears in that same period.
- led_en = 1 in GRANT and GUARD, 0 in IDLE.

Optional Feature:
- LED_FADE_EN defined: in GRANT, each channel's duty_latched moves one LSB per boundary toward color[owner], giving a linear fade. GUARD still forces duty to 0 immediately.
- LED_FADE_EN undefined: duty_latched loads the target directly at the boundary.

Test Plan:
Bench parameters: PRESCALE=2, PWM_BITS=4, MIN_HOLD=2, GUARD_PERIODS=1, giving a 32-cycle period.
1. rst high 3 cycles, then low with req=0 -> gnt=0, led_en=0, all PWM low. period_start pulses every 32 cycles, the first 32 cycles after rst release.
2. req[1]=1 with color[1]={4,0,15} -> gnt=3'b010 after the next boundary. Per period: red high 8 cycles, green 0 cycles, blue 30 cycles; led_en=1.
3. Owner 1 active and hold < 2, then req[0] asserted -> no preemption until 2 periods have completed. Then: one guard period with all PWM low, gnt=0, led_en=1; next period gnt=3'b001.
4. req[2] and req[1] asserted in the same cycle -> gnt=3'b010. Owner 1 drops req mid-period -> gnt holds to the boundary, then a guard period, then gnt=3'b100.
5. rst pulsed for 1 cycle during GRANT -> the next cycle shows gnt=0, outputs 0, pwm_cnt=0 and state IDLE. Re-grant follows after the next boundary.
6. With LED_FADE_EN defined, color {15,0,0} granted from IDLE -> red duty reaches 1, 2, … 15 over 15 consecutive periods.
